// File: rtl/mesh_inject_arbiter.sv
// Round-robin arbiter sharing one mesh router local injection port among N_REQ requesters,
// with a one-entry registered output stage and per-requester outstanding-credit limiting.
module mesh_inject_arbiter #(
    parameter  int W               = 8,
    parameter  int X_SIZE          = 4,
    parameter  int Y_SIZE          = 4,
    parameter  int N_REQ           = 4,
    parameter  int MAX_OUTSTANDING = 4,
    localparam int XW              = $clog2(X_SIZE),
    localparam int YW              = $clog2(Y_SIZE),
    localparam int IW              = $clog2(N_REQ),
    localparam int CW              = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    i_req_valid,
    input  logic [N_REQ*XW-1:0] i_req_dst_x,
    input  logic [N_REQ*YW-1:0] i_req_dst_y,
    input  logic [N_REQ*W-1:0]  i_req_payload,
    output logic [N_REQ-1:0]    o_req_ready,
    output logic                o_valid,
    output logic [XW-1:0]       o_dst_x,
    output logic [YW-1:0]       o_dst_y,
    output logic [W-1:0]        o_payload,
    output logic [IW-1:0]       o_src_id,
    input  logic                i_ready,
    input  logic                i_done_valid,
    input  logic [IW-1:0]       i_done_id,
    output logic                o_credit_err
);

    logic [CW-1:0]    cnt [N_REQ];
    logic [IW-1:0]    ptr;
    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] inc_vec;
    logic [N_REQ-1:0] dec_vec;
    logic [CW-1:0]    cnt_sel;
    logic [IW-1:0]    grant;
    logic             grant_found;
    logic             load;
    logic             accept;
    logic             done_in_range;
    logic             done_err;

    always_comb begin
        int unsigned idx;
        idx         = 0;
        grant_found = 1'b0;
        grant       = '0;
        // Scan ptr+1 .. ptr+N_REQ so the last-granted requester has lowest priority.
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx = (32'(ptr) + i) % N_REQ;
            if (!grant_found && eligible[idx]) begin
                grant_found = 1'b1;
                grant       = IW'(idx);
            end
        end
    end

    assign load        = !o_valid || i_ready;
    assign accept      = load && grant_found;
    assign o_req_ready = accept ? (N_REQ'(1) << grant) : '0;

    always_comb begin
        eligible = '0;
        inc_vec  = '0;
        dec_vec  = '0;
        cnt_sel  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            eligible[k] = i_req_valid[k] && (cnt[k] < CW'(MAX_OUTSTANDING));
            inc_vec[k]  = accept && (grant == IW'(k));
            dec_vec[k]  = i_done_valid && (i_done_id == IW'(k)) && (cnt[k] != '0);
            if (i_done_id == IW'(k)) begin
                cnt_sel = cnt[k];
            end
        end
    end

    assign done_in_range = 32'(i_done_id) < N_REQ;
    assign done_err      = i_done_valid && (!done_in_range || (cnt_sel == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                cnt[k] <= '0;
            end
            ptr          <= IW'(N_REQ - 1);
            o_valid      <= 1'b0;
            o_dst_x      <= '0;
            o_dst_y      <= '0;
            o_payload    <= '0;
            o_src_id     <= '0;
            o_credit_err <= 1'b0;
        end else begin
            // Accept and return on the same requester cancel out.
            for (int unsigned k = 0; k < N_REQ; k++) begin
                if (inc_vec[k] && !dec_vec[k]) begin
                    cnt[k] <= cnt[k] + CW'(1);
                end else if (dec_vec[k] && !inc_vec[k]) begin
                    cnt[k] <= cnt[k] - CW'(1);
                end
            end
            if (accept) begin
                o_valid   <= 1'b1;
                o_dst_x   <= i_req_dst_x[grant*XW +: XW];
                o_dst_y   <= i_req_dst_y[grant*YW +: YW];
                o_payload <= i_req_payload[grant*W +: W];
                o_src_id  <= grant;
                ptr       <= grant;
            end else if (i_ready) begin
                o_valid <= 1'b0;
            end
            if (done_err) begin
                o_credit_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mesh_inject_arbiter.sv
// Randomized and directed bench for mesh_inject_arbiter against a transaction-level model
// of grant order, credit counts and the output stage.
module tb_mesh_inject_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [7:0]  dst_x;
    logic [7:0]  dst_y;
    logic [31:0] payload;
    logic [3:0]  o_req_ready;
    logic        o_valid;
    logic [1:0]  o_dst_x;
    logic [1:0]  o_dst_y;
    logic [7:0]  o_payload;
    logic [1:0]  o_src_id;
    logic        i_ready;
    logic        done_valid;
    logic [1:0]  done_id;
    logic        o_credit_err;

    always #5 clk = ~clk;

    mesh_inject_arbiter #(
        .W(8), .X_SIZE(4), .Y_SIZE(4), .N_REQ(4), .MAX_OUTSTANDING(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(req_valid), .i_req_dst_x(dst_x), .i_req_dst_y(dst_y),
        .i_req_payload(payload), .o_req_ready(o_req_ready),
        .o_valid(o_valid), .o_dst_x(o_dst_x), .o_dst_y(o_dst_y),
        .o_payload(o_payload), .o_src_id(o_src_id), .i_ready(i_ready),
        .i_done_valid(done_valid), .i_done_id(done_id), .o_credit_err(o_credit_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: credits in use, last winner, and contents of the output stage.
    int m_cnt [4];
    int m_ptr;
    int m_ov, m_x, m_y, m_pl, m_src, m_err;

    int cap_ready, cap_valid, cap_payload, cap_src, cap_err, cap_x, cap_y;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) m_cnt[k] = 0;
        m_ptr = 3; m_ov = 0; m_x = 0; m_y = 0; m_pl = 0; m_src = 0; m_err = 0;
    endtask

    function automatic int model_grant();
        if (m_ov != 0 && !i_ready) return -1;
        for (int j = 1; j <= 4; j++) begin
            int k;
            k = (m_ptr + j) % 4;
            if (req_valid[k] && m_cnt[k] < 4) return k;
        end
        return -1;
    endfunction

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step();
        int g;
        #1;
        g = model_grant();
        chk("req_ready", int'(o_req_ready), (g < 0) ? 0 : (1 << g));
        chk("valid", int'(o_valid), m_ov);
        chk("src_id", int'(o_src_id), m_src);
        chk("dst_x", int'(o_dst_x), m_x);
        chk("dst_y", int'(o_dst_y), m_y);
        chk("payload", int'(o_payload), m_pl);
        chk("credit_err", int'(o_credit_err), m_err);
        cap_ready = int'(o_req_ready); cap_valid = int'(o_valid); cap_payload = int'(o_payload);
        cap_src = int'(o_src_id); cap_err = int'(o_credit_err);
        cap_x = int'(o_dst_x); cap_y = int'(o_dst_y);
        @(posedge clk);
        if (done_valid) begin
            if (m_cnt[done_id] == 0) m_err = 1;
            else m_cnt[done_id]--;
        end
        if (g >= 0) begin
            m_ov = 1; m_src = g; m_ptr = g; m_cnt[g]++;
            m_x = int'(dst_x[g*2 +: 2]); m_y = int'(dst_y[g*2 +: 2]); m_pl = int'(payload[g*8 +: 8]);
        end else if (i_ready) begin
            m_ov = 0;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        req_valid = '0; i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            while (m_cnt[k] > 0) begin
                done_valid = 1'b1; done_id = 2'(k);
                step();
            end
        end
        done_valid = 1'b0;
        step();
    endtask

    initial begin
        int acc;
        int xfers;
        rst_n = 1'b0; req_valid = '0; dst_x = '0; dst_y = '0; payload = '0;
        i_ready = 1'b0; done_valid = 1'b0; done_id = '0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_ready", int'(o_req_ready), 0);
        chk("rst_err", int'(o_credit_err), 0);
        chk("rst_payload", int'(o_payload), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Credit return with nothing outstanding
        done_valid = 1'b1; done_id = 2'd0;
        step();
        done_valid = 1'b0;
        step();
        chk("t6_err_set", cap_err, 1);

        // First grant after reset goes to requester 0
        req_valid = 4'b0001; payload = 32'h0000_0011; i_ready = 1'b1;
        step();
        chk("t1_grant0", cap_ready, 1);
        req_valid = '0;
        step();
        chk("t1_valid", cap_valid, 1);
        chk("t1_src", cap_src, 0);
        chk("t1_pl", cap_payload, 8'h11);

        // Backpressure: stage must freeze while the router stalls
        drain();
        req_valid = 4'b0100; dst_x = 8'b0011_0000; dst_y = 8'b0001_0000;
        payload = 32'h00A5_0000; i_ready = 1'b0;
        step();
        req_valid = 4'b1011; payload = 32'h773C_5566;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_valid", cap_valid, 1);
            chk("t3_pl", cap_payload, 8'hA5);
            chk("t3_src", cap_src, 2);
            chk("t3_xy", cap_x * 4 + cap_y, 3 * 4 + 1);
            chk("t3_ready", cap_ready, 0);
        end
        req_valid = '0; i_ready = 1'b1; xfers = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (cap_valid != 0 && cap_payload == 8'hA5) xfers++;
        end
        chk("t3_xfers", xfers, 1);

        // Credit limit on a single requester
        drain();
        req_valid = 4'b0010; acc = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (cap_ready[1]) acc++;
        end
        chk("t4_accepts", acc, 4);
        done_valid = 1'b1; done_id = 2'd1;
        step();
        chk("t4_blocked", cap_ready, 0);
        done_valid = 1'b0;
        step();
        chk("t4_fifth", cap_ready, 2);

        // Accept and credit return on the same requester in one cycle
        drain();
        req_valid = 4'b1000;
        step(); step();
        done_valid = 1'b1; done_id = 2'd3;
        step();
        chk("t5_accept", cap_ready, 8);
        done_valid = 1'b0; acc = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (cap_ready[3]) acc++;
        end
        chk("t5_more", acc, 2);

        // Fairness at full throughput
        drain();
        req_valid = 4'hF;
        for (int i = 0; i < 10; i++) begin
            payload = $urandom; dst_x = 8'($urandom); dst_y = 8'($urandom);
            done_valid = (m_ov != 0); done_id = 2'(m_src);
            step();
            chk("t2_grant", cap_ready, 1 << (i % 4));
            if (i > 0) begin
                chk("t2_valid", cap_valid, 1);
                chk("t2_src", cap_src, (i - 1) % 4);
            end
        end
        chk("t6_sticky", cap_err, 1);

        // Asynchronous reset while a packet sits in the stage
        req_valid = '0; done_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", int'(o_valid), 0);
        chk("mid_rst_err", int'(o_credit_err), 0);
        chk("mid_rst_ready", int'(o_req_ready), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 3000; i++) begin
            req_valid = 4'($urandom);
            dst_x = 8'($urandom); dst_y = 8'($urandom); payload = $urandom;
            i_ready = ($urandom_range(0, 9) < 7);
            done_valid = ($urandom_range(0, 9) < 4);
            done_id = 2'($urandom_range(0, 3));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
